// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and small helpers for the one-hot round-robin arbiter.
// Only eight request lines are supported so that the grant matches the downstream 8-to-3 encoder.
package onehot_rr_arbiter_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot vector; zero for an all-zero vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [N-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set bit of vec searching upward from ptr, as one-hot.
// Rotates right by ptr, isolates the lowest set bit, then rotates the result back.
module onehot_rr_arbiter_rr_pick
  import onehot_rr_arbiter_pkg::*;
(
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] iso;

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    rot   = '0;
    iso   = '0;
    grant = '0;
    // 3-bit index arithmetic wraps modulo 8, which is exactly the rotation.
    for (int i = 0; i < N; i++) begin
      rot[i] = vec[IDX_W'(i) + ptr];
    end
    iso = rot & (~rot + N'(1));
    for (int i = 0; i < N; i++) begin
      grant[IDX_W'(i) + ptr] = iso[i];
    end
  end

  assign any = |vec;

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: captures request rising edges into a sticky pending register and
// hands out one pending request at a time as a stable one-hot grant under valid/ready.
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N      = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      grant_out,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [N-1:0]      pending_out,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t           state;
  logic [N-1:0]     req_d;
  logic [N-1:0]     pending;
  logic [IDX_W-1:0] ptr;

  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic [N-1:0]     next_pending;
  logic [N-1:0]     drop_bits;
  logic             accept;
  logic [IDX_W-1:0] ptr_next;
  logic [N-1:0]     pick_vec;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_oh;
  logic             pick_any;
  logic [DROP_W:0]  drop_sum;

  assign accept       = grant_valid & grant_ready;
  assign rise         = req_in & ~req_d;
  assign clr          = accept ? grant_out : '0;
  assign next_pending = (pending & ~clr) | rise;
  assign drop_bits    = rise & pending & ~clr;
  assign ptr_next     = onehot_to_idx(grant_out) + IDX_W'(1);
  assign drop_sum     = {1'b0, drop_cnt} + (DROP_W+1)'(popcount(drop_bits));

  // From IDLE the pick sees only the registered pending set; in GRANT it sees the
  // post-accept set against the advanced pointer so grants can run back to back.
  assign pick_vec = (state == GRANT) ? next_pending : pending;
  assign pick_ptr = (state == GRANT) ? ptr_next : ptr;

  onehot_rr_arbiter_rr_pick u_rr_pick (
    .vec   (pick_vec),
    .ptr   (pick_ptr),
    .grant (pick_oh),
    .any   (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      req_d    <= req_in;
      pending  <= next_pending;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_out   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_out   <= pick_oh;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr <= ptr_next;
            if (pick_any) begin
              grant_out <= pick_oh;
            end else begin
              grant_out   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_out   <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pending_out = pending;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_onehot_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic [7:0] grant_out;
  logic       grant_valid;
  logic [7:0] pending_out;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  onehot_rr_arbiter #(.N(8), .DROP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req),
    .grant_out   (grant_out),
    .grant_valid (grant_valid),
    .grant_ready (ready),
    .pending_out (pending_out),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and integer search, derived from the arbitration rules.
  bit m_pend[8];
  bit m_prev[8];
  int m_ptr;
  int m_gidx;
  int m_drops;
  bit m_valid;

  function automatic int first_from(input bit v[8], input int from);
    for (int k = 0; k < 8; k++) begin
      if (v[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_ptr   = 0;
    m_gidx  = 0;
    m_drops = 0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_step();
    bit nxt[8];
    int clr_idx;
    int f;
    clr_idx = (m_valid && ready) ? m_gidx : -1;
    for (int i = 0; i < 8; i++) begin
      bit r;
      r = req[i] && !m_prev[i];
      if (r && m_pend[i] && i != clr_idx) m_drops++;
      nxt[i]    = (m_pend[i] && i != clr_idx) || r;
      m_prev[i] = req[i];
    end
    if (m_drops > 255) m_drops = 255;
    if (m_valid) begin
      if (ready) begin
        m_ptr = (m_gidx + 1) % 8;
        f = first_from(nxt, m_ptr);
        if (f < 0) m_valid = 1'b0;
        else       m_gidx  = f;
      end
    end else begin
      f = first_from(m_pend, m_ptr);
      if (f >= 0) begin
        m_valid = 1'b1;
        m_gidx  = f;
      end
    end
    m_pend = nxt;
  endfunction

  function automatic logic [7:0] model_grant();
    logic [7:0] g;
    g = '0;
    if (m_valid) g[m_gidx] = 1'b1;
    return g;
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [7:0] grant;
    logic       valid;
    logic [7:0] pend;
    logic [2:0] ptr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    model_reset();

    // Single request, then round-robin sweep and wrap (each block starts from reset).
    tbl.push_back('{1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 8'h04, 3'd0});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 3'd0});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 3'd3});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd3});
    tbl.push_back('{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'hFF, 3'd0});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 8'hFF, 3'd0});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'hFE, 3'd1});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 8'hFC, 3'd2});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h08, 1'b1, 8'hF8, 3'd3});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 8'hF0, 3'd4});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1, 8'hE0, 3'd5});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1, 8'hC0, 3'd6});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1, 8'h80, 3'd7});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0});
    tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 8'h81, 3'd0});
    tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h01, 1'b1, 8'h81, 3'd0});
    tbl.push_back('{1'b0, 8'h81, 1'b1, 8'h80, 1'b1, 8'h80, 3'd1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0});

    do_reset();
    #1;
    check("reset grant", 32'(grant_out), 32'h0);
    check("reset valid", 32'(grant_valid), 32'h0);
    check("reset pending", 32'(pending_out), 32'h0);
    check("reset drops", 32'(drop_cnt), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      req   = tbl[i].req;
      ready = tbl[i].ready;
      step();
      check($sformatf("table[%0d] grant", i), 32'(grant_out), 32'(tbl[i].grant));
      check($sformatf("table[%0d] valid", i), 32'(grant_valid), 32'(tbl[i].valid));
      check($sformatf("table[%0d] pending", i), 32'(pending_out), 32'(tbl[i].pend));
      check($sformatf("table[%0d] ptr", i), 32'(dut.ptr), 32'(tbl[i].ptr));
    end

    // Backpressure: grant held stable while ready is low.
    do_reset();
    req = 8'h10; ready = 1'b0;
    step();
    check("bp pending", 32'(pending_out), 32'h10);
    check("bp not yet valid", 32'(grant_valid), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp hold grant %0d", i), 32'(grant_out), 32'h10);
      check($sformatf("bp hold valid %0d", i), 32'(grant_valid), 32'h1);
    end
    ready = 1'b1;
    step();
    check("bp release grant", 32'(grant_out), 32'h0);
    check("bp release valid", 32'(grant_valid), 32'h0);
    check("bp release pending", 32'(pending_out), 32'h0);

    // Set/clear collision: the re-rise of bit 1 lands on its own accept.
    do_reset();
    req = 8'h02; ready = 1'b0;
    step();
    step();
    check("coll first grant", 32'(grant_out), 32'h02);
    req = 8'h00;
    step();
    req = 8'h02; ready = 1'b1;
    step();
    check("coll pending kept", 32'(pending_out), 32'h02);
    check("coll regrant", 32'(grant_out), 32'h02);
    check("coll regrant valid", 32'(grant_valid), 32'h1);
    check("coll no drop", 32'(drop_cnt), 32'h0);
    step();
    check("coll drained valid", 32'(grant_valid), 32'h0);
    check("coll drained pending", 32'(pending_out), 32'h0);

    // Drops saturate while the line is pending and not accepted.
    do_reset();
    req = 8'h20; ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 300; i++) begin
      req = 8'h00;
      step();
      req = 8'h20;
      step();
    end
    check("drop saturated", 32'(drop_cnt), 32'hFF);
    check("drop pending", 32'(pending_out), 32'h20);
    check("drop grant held", 32'(grant_out), 32'h20);

    // Asynchronous reset between edges while a grant is valid.
    req = 8'h08;
    step();
    check("pre-reset valid", 32'(grant_valid), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("async grant", 32'(grant_out), 32'h0);
    check("async valid", 32'(grant_valid), 32'h0);
    check("async pending", 32'(pending_out), 32'h0);
    check("async drops", 32'(drop_cnt), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("held line re-registers", 32'(pending_out), 32'h08);
    step();
    check("held line granted", 32'(grant_out), 32'h08);
    ready = 1'b1;
    step();
    step();
    step();
    check("held line no re-request pending", 32'(pending_out), 32'h0);
    check("held line no re-request valid", 32'(grant_valid), 32'h0);

    // Randomized traffic against the reference model.
    req = '0; ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req   = req ^ 8'($urandom & $urandom & $urandom);
      ready = ($urandom_range(0, 3) != 0);
      step();
      check("rand grant", 32'(grant_out), 32'(model_grant()));
      check("rand valid", 32'(grant_valid), 32'(m_valid));
      check("rand pending", 32'(pending_out), 32'(model_pending()));
      check("rand drops", 32'(drop_cnt), 32'(m_drops));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
